// File: rtl/tas_shift_if.sv
// Host-side frame write channel for tas_shift_engine.
// valid/ready: a frame transfers on any clk edge where wr_valid && wr_ready; wr_data must be stable while wr_valid is high.
interface tas_shift_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2
);
    logic                      wr_valid;
    logic                      wr_ready;
    logic [CHANNELS*WIDTH-1:0] wr_data;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/tas_shift_engine.sv
// Multi-channel console serial output engine: frame FIFO, synchronised latch/clock strobes, MSB-first shifting.
// Optional feature macro: TAS_SHIFT_REPEAT_EN (an empty-FIFO latch replays the last loaded frame).
module tas_shift_engine #(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 2,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        con_latch,
    input  logic                        con_clk,
    tas_shift_if.slave                  wr,
    input  logic [CHANNELS-1:0]         overread,
    output logic [CHANNELS-1:0]         data_out,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic [15:0]                 frame_count,
    output logic [7:0]                  underflow_count,
    output logic [$clog2(WIDTH+1)-1:0]  dbg_bit_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef logic [CHANNELS-1:0][WIDTH-1:0] frame_t;

    logic [SYNC_STAGES-1:0] lat_sync_q, lat_sync_d, clk_sync_q, clk_sync_d;
    logic                   lat_last_q, lat_last_d, clk_last_q, clk_last_d;
    logic                   lat_rise_q, lat_rise_d, clk_rise_q, clk_rise_d;

    frame_t                 mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    frame_t                 shreg_q, shreg_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic [7:0]             uflow_q, uflow_d;
    logic                   push, pop;
`ifdef TAS_SHIFT_REPEAT_EN
    frame_t                 last_q, last_d;
`endif

    assign wr.wr_ready      = (level_q != LW'(DEPTH));
    assign push             = wr.wr_valid && wr.wr_ready;
    assign pop              = lat_rise_q && (level_q != '0);
    assign fifo_level       = level_q;
    assign frame_count      = frame_cnt_q;
    assign underflow_count  = uflow_q;
    assign dbg_bit_cnt      = bit_cnt_q;

    // Rise pulses are registered so a latch and a clock edge seen together can be arbitrated in one cycle.
    always_comb begin
        lat_sync_d = {lat_sync_q[SYNC_STAGES-2:0], con_latch};
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], con_clk};
        lat_last_d = lat_sync_q[SYNC_STAGES-1];
        clk_last_d = clk_sync_q[SYNC_STAGES-1];
        lat_rise_d = lat_sync_q[SYNC_STAGES-1] & ~lat_last_q;
        clk_rise_d = clk_sync_q[SYNC_STAGES-1] & ~clk_last_q;
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d     = level_q + LW'(push) - LW'(pop);
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        uflow_d     = uflow_q;
`ifdef TAS_SHIFT_REPEAT_EN
        last_d      = last_q;
`endif
        if (lat_rise_q) begin
            bit_cnt_d = '0;
            if (pop) begin
                shreg_d     = mem_q[rd_ptr_q];
                frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef TAS_SHIFT_REPEAT_EN
                last_d      = mem_q[rd_ptr_q];
`endif
            end else begin
                if (uflow_q != 8'hFF) uflow_d = uflow_q + 8'd1;
`ifdef TAS_SHIFT_REPEAT_EN
                shreg_d = last_q;
`else
                shreg_d = '1;
`endif
            end
        end else if (clk_rise_q && !lat_last_q) begin
            for (int c = 0; c < CHANNELS; c++) begin
                shreg_d[c] = {shreg_q[c][WIDTH-2:0], overread[c]};
            end
            if (bit_cnt_q != CW'(WIDTH)) bit_cnt_d = bit_cnt_q + CW'(1);
        end
    end

    // The serial output is the shift register MSB, so it is registered by construction.
    always_comb begin
        data_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            data_out[c] = shreg_q[c][WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= frame_t'(wr.wr_data);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_sync_q  <= '0;
            clk_sync_q  <= '0;
            lat_last_q  <= 1'b0;
            clk_last_q  <= 1'b0;
            lat_rise_q  <= 1'b0;
            clk_rise_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            shreg_q     <= '1;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            uflow_q     <= '0;
`ifdef TAS_SHIFT_REPEAT_EN
            last_q      <= '1;
`endif
        end else begin
            lat_sync_q  <= lat_sync_d;
            clk_sync_q  <= clk_sync_d;
            lat_last_q  <= lat_last_d;
            clk_last_q  <= clk_last_d;
            lat_rise_q  <= lat_rise_d;
            clk_rise_q  <= clk_rise_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            uflow_q     <= uflow_d;
`ifdef TAS_SHIFT_REPEAT_EN
            last_q      <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_tas_shift_engine.sv
// Directed and randomized bench for tas_shift_engine against a frame-level reference model.
// Honours TAS_SHIFT_REPEAT_EN in the same way as the design build.
module tb_tas_shift_engine;
    localparam int WIDTH    = 16;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 8;
    localparam int SYNC     = 2;
    localparam int HOLD     = 6;
    localparam int FW       = CHANNELS * WIDTH;

    logic                             clk = 1'b0;
    logic                             rst_n;
    logic                             con_latch, con_clk;
    logic [CHANNELS-1:0]              overread;
    logic [CHANNELS-1:0]              data_out;
    logic [$clog2(DEPTH):0]           fifo_level;
    logic [15:0]                      frame_count;
    logic [7:0]                       underflow_count;
    logic [$clog2(WIDTH+1)-1:0]       dbg_bit_cnt;

    tas_shift_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    tas_shift_engine #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .con_latch       (con_latch),
        .con_clk         (con_clk),
        .wr              (bus.slave),
        .overread        (overread),
        .data_out        (data_out),
        .fifo_level      (fifo_level),
        .frame_count     (frame_count),
        .underflow_count (underflow_count),
        .dbg_bit_cnt     (dbg_bit_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: queued frames, the frame being played, and counters.
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] cur_frame, last_frame;
    logic [CHANNELS-1:0] cur_ovr;
    int shifts;
    int exp_fc, exp_uf;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CHANNELS-1:0] model_dout();
        logic [CHANNELS-1:0] d;
        for (int c = 0; c < CHANNELS; c++)
            d[c] = (shifts < WIDTH) ? cur_frame[c*WIDTH + WIDTH - 1 - shifts] : cur_ovr[c];
        return d;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        cur_frame  = '1;
        last_frame = '1;
        shifts     = 0;
        exp_fc     = 0;
        exp_uf     = 0;
    endtask

    task automatic model_latch();
        if (exp_q.size() > 0) begin
            cur_frame  = exp_q.pop_front();
            last_frame = cur_frame;
            exp_fc     = (exp_fc + 1) % 65536;
        end else begin
            if (exp_uf < 255) exp_uf++;
`ifdef TAS_SHIFT_REPEAT_EN
            cur_frame = last_frame;
`else
            cur_frame = '1;
`endif
        end
        shifts = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [FW-1:0] f);
        bus.wr_valid = 1'b1;
        bus.wr_data  = f;
        if (exp_q.size() < DEPTH) exp_q.push_back(f);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic latch_pulse();
        con_latch = 1'b1;
        repeat (HOLD) tick();
        con_latch = 1'b0;
        repeat (HOLD) tick();
        model_latch();
    endtask

    task automatic clk_pulse();
        con_clk = 1'b1;
        repeat (HOLD) tick();
        con_clk = 1'b0;
        repeat (HOLD) tick();
        if (shifts <= WIDTH) shifts++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"}, 64'(data_out), 64'(model_dout()));
        check({tag, ".level"}, 64'(fifo_level), 64'(exp_q.size()));
        check({tag, ".wr_ready"}, 64'(bus.wr_ready), 64'(exp_q.size() != DEPTH));
        check({tag, ".frame_count"}, 64'(frame_count), 64'(exp_fc));
        check({tag, ".underflow"}, 64'(underflow_count), 64'(exp_uf));
        check({tag, ".bit_cnt"}, 64'(dbg_bit_cnt), 64'((shifts > WIDTH) ? WIDTH : shifts));
    endtask

    initial begin
        rst_n        = 1'b0;
        con_latch    = 1'b0;
        con_clk      = 1'b0;
        overread     = '0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        cur_ovr      = '0;
        model_reset();
        repeat (3) tick();
        check("reset.data_out", 64'(data_out), 64'(2'b11));
        check("reset.wr_ready", 64'(bus.wr_ready), 64'(1));
        check_all("reset");
        rst_n = 1'b1;
        tick();

        // Directed frame A5C3 / 0F0F with overread 01.
        overread = 2'b01; cur_ovr = 2'b01;
        push({16'h0F0F, 16'hA5C3});
        latch_pulse();
        check_all("dir.load");
        for (int i = 0; i < WIDTH + 2; i++) begin
            clk_pulse();
            check_all("dir.shift");
        end
        check("dir.frame_count", 64'(frame_count), 64'(1));
        check("dir.tail", 64'(data_out), 64'(2'b01));

        // Fill to full, refused ninth push, pop latency.
        for (int i = 0; i < DEPTH; i++) push(FW'($urandom));
        check_all("full");
        check("full.level", 64'(fifo_level), 64'(DEPTH));
        push(FW'($urandom));
        check("ninth.level", 64'(fifo_level), 64'(DEPTH));
        check("ninth.ready", 64'(bus.wr_ready), 64'(0));
        con_latch = 1'b1;
        repeat (SYNC + 1) tick();
        check("pop.before", 64'(fifo_level), 64'(DEPTH));
        tick();
        check("pop.level", 64'(fifo_level), 64'(DEPTH - 1));
        check("pop.ready", 64'(bus.wr_ready), 64'(1));
        repeat (HOLD - SYNC - 2) tick();
        con_latch = 1'b0;
        repeat (HOLD) tick();
        model_latch();
        check_all("pop");

        // Randomized traffic drains the queue and exercises underflow.
        for (int it = 0; it < 24; it++) begin
            int np, nc;
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) push(FW'({$urandom, $urandom}));
            overread = CHANNELS'($urandom); cur_ovr = overread;
            latch_pulse();
            check_all("rnd.load");
            nc = $urandom_range(0, WIDTH + 2);
            for (int k = 0; k < nc; k++) begin
                clk_pulse();
                check("rnd.shift", 64'(data_out), 64'(model_dout()));
            end
            check_all("rnd.end");
        end

        // Empty FIFO after frame 1234: repeat or all-ones.
        rst_n = 1'b0; tick(); rst_n = 1'b1; model_reset(); tick();
        overread = 2'b00; cur_ovr = 2'b00;
        push({16'h1234, 16'h1234});
        latch_pulse();
        for (int i = 0; i < WIDTH; i++) clk_pulse();
        check_all("f1234.done");
        latch_pulse();
        check("empty.underflow", 64'(underflow_count), 64'(1));
        for (int i = 0; i < WIDTH; i++) begin
            check("empty.serial", 64'(data_out), 64'(model_dout()));
            clk_pulse();
        end
        check_all("empty.end");

        // Latch and clock rising together, then clock pulses while latch is high.
        push(FW'({$urandom, $urandom}));
        overread = 2'b10; cur_ovr = 2'b10;
        con_latch = 1'b1; con_clk = 1'b1;
        repeat (HOLD) tick();
        model_latch();
        check_all("same.load");
        con_clk = 1'b0; repeat (HOLD) tick();
        con_clk = 1'b1; repeat (HOLD) tick();
        check_all("same.hold");
        con_clk = 1'b0; con_latch = 1'b0;
        repeat (HOLD) tick();
        clk_pulse();
        check_all("same.after");

        // Reset mid-frame with three frames queued.
        for (int i = 0; i < 4; i++) push(FW'({$urandom, $urandom}));
        latch_pulse();
        for (int i = 0; i < 5; i++) clk_pulse();
        check_all("mid.before");
        rst_n = 1'b0;
        tick();
        model_reset();
        check_all("mid.reset");
        rst_n = 1'b1;
        tick();
        latch_pulse();
        check_all("mid.latch");

        // Underflow saturation.
        for (int i = 0; i < 256; i++) latch_pulse();
        check("sat.underflow", 64'(underflow_count), 64'(8'hFF));
        check_all("sat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
